// File: rtl/frag_stream_arbiter_if.sv
// Requester fan-in plus merged output stream of frag_stream_arbiter.
// The arbiter connects to the slave modport; the requesters and downstream FIFO use the master modport.
interface frag_stream_arbiter_if #(
    parameter int NUM_REQ = 4,
    parameter int WIDTH   = 64,
    parameter int SRC_W   = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1
);
    logic [NUM_REQ-1:0]       req_vld;
    logic [NUM_REQ*WIDTH-1:0] req_data;
    logic [NUM_REQ-1:0]       req_last;
    logic [NUM_REQ-1:0]       req_rdy;
    logic                     out_vld;
    logic [WIDTH-1:0]         out_data;
    logic                     out_last;
    logic [SRC_W-1:0]         out_src;
    logic                     out_rdy;
    logic                     busy;

    modport master (
        output req_vld, req_data, req_last, out_rdy,
        input  req_rdy, out_vld, out_data, out_last, out_src, busy
    );

    modport slave (
        input  req_vld, req_data, req_last, out_rdy,
        output req_rdy, out_vld, out_data, out_last, out_src, busy
    );
endinterface

// File: rtl/frag_stream_arbiter.sv
// Round-robin, packet-locked merge of NUM_REQ fragment streams into one registered,
// source-tagged stream. A grant is held from a packet's first beat through its last beat.
module frag_stream_arbiter #(
    parameter int NUM_REQ = 4,
    parameter int WIDTH   = 64,
    parameter int SRC_W   = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1
) (
    input logic                  clk,
    input logic                  rst,
    frag_stream_arbiter_if.slave bus
);
    typedef enum logic {IDLE = 1'b0, LOCK = 1'b1} state_t;

    state_t           state_reg, state_next;
    logic [SRC_W-1:0] grant_reg, grant_next;
    logic [SRC_W-1:0] ptr_reg, ptr_next;
    logic             out_vld_reg, out_vld_next;
    logic [WIDTH-1:0] out_data_reg, out_data_next;
    logic             out_last_reg, out_last_next;
    logic [SRC_W-1:0] out_src_reg, out_src_next;

    logic             load_ok;
    logic             accept;
    logic [SRC_W-1:0] pick;
    logic [SRC_W-1:0] grant_inc;
    logic [WIDTH-1:0] lane_data [NUM_REQ];
    logic [SRC_W-1:0] cand      [NUM_REQ];

    // cand[k] is requester (ptr + k) mod NUM_REQ, so search order starts at ptr.
    genvar gi;
    generate
        for (gi = 0; gi < NUM_REQ; gi++) begin : g_lane
            logic [SRC_W:0] sum;
            assign lane_data[gi]   = bus.req_data[gi*WIDTH +: WIDTH];
            assign sum             = {1'b0, ptr_reg} + (SRC_W+1)'(gi);
            assign cand[gi]        = (sum >= (SRC_W+1)'(NUM_REQ))
                                   ? SRC_W'(sum - (SRC_W+1)'(NUM_REQ))
                                   : SRC_W'(sum);
            assign bus.req_rdy[gi] = (state_reg == LOCK) && load_ok && (grant_reg == SRC_W'(gi));
        end
    endgenerate

    // Walking down from the far end lets the closest valid requester to ptr win.
    always_comb begin
        pick = ptr_reg;
        for (int k = NUM_REQ - 1; k >= 0; k--) begin
            if (bus.req_vld[cand[k]]) begin
                pick = cand[k];
            end
        end
    end

    assign grant_inc = (grant_reg == SRC_W'(NUM_REQ - 1)) ? '0 : grant_reg + 1'b1;
    assign load_ok   = !out_vld_reg || bus.out_rdy;
    assign accept    = (state_reg == LOCK) && load_ok && bus.req_vld[grant_reg];

    always_comb begin
        state_next    = state_reg;
        grant_next    = grant_reg;
        ptr_next      = ptr_reg;
        out_vld_next  = out_vld_reg;
        out_data_next = out_data_reg;
        out_last_next = out_last_reg;
        out_src_next  = out_src_reg;

        case (state_reg)
            IDLE: begin
                if (|bus.req_vld) begin
                    grant_next = pick;
                    state_next = LOCK;
                end
            end
            LOCK: begin
                if (accept && bus.req_last[grant_reg]) begin
                    state_next = IDLE;
                    ptr_next   = grant_inc;
                end
            end
            default: state_next = IDLE;
        endcase

        // A load in the same cycle as a pop keeps out_vld high with the new beat.
        if (accept) begin
            out_vld_next  = 1'b1;
            out_data_next = lane_data[grant_reg];
            out_last_next = bus.req_last[grant_reg];
            out_src_next  = grant_reg;
        end else if (out_vld_reg && bus.out_rdy) begin
            out_vld_next = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_reg    <= IDLE;
            grant_reg    <= '0;
            ptr_reg      <= '0;
            out_vld_reg  <= 1'b0;
            out_data_reg <= '0;
            out_last_reg <= 1'b0;
            out_src_reg  <= '0;
        end else begin
            state_reg    <= state_next;
            grant_reg    <= grant_next;
            ptr_reg      <= ptr_next;
            out_vld_reg  <= out_vld_next;
            out_data_reg <= out_data_next;
            out_last_reg <= out_last_next;
            out_src_reg  <= out_src_next;
        end
    end

    assign bus.out_vld  = out_vld_reg;
    assign bus.out_data = out_data_reg;
    assign bus.out_last = out_last_reg;
    assign bus.out_src  = out_src_reg;
    assign bus.busy     = (state_reg == LOCK) || out_vld_reg;
endmodule
